flash_master: RTL and testbench

Initiator-side controller for the on-chip `flash` array. It accepts single or burst read/write requests from the host over a valid/ready handshake, sequences the flash `cs`/`we`/`re`/`addr`/`in` strobes and returns read data with fixed latency. Writes that would touch the write-protected top sector (addr[23:20] == 4'hF) are refused before any flash cycle is issued. The block sits between the CPU/DMA bus bridge and the `flash` instance.

---
 rtl/flash_master.sv | 191 +++++++++++++++++++
 tb/tb_flash_master.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_master.sv
// flash_master: host-side sequencer for the on-chip flash array.
// Accepts single/burst read and write requests over valid/ready, drives
// registered flash strobes, and returns read data two cycles after each
// read strobe. Writes reaching the top sector (addr[23:20] == 4'hF) are
// refused without touching the flash or consuming write data.
module flash_master #(
  parameter int MAX_LEN = 256,
  parameter int LEN_W   = $clog2(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [23:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic [7:0]       wdata,
  input  logic             wdata_valid,
  output logic             wdata_ready,
  output logic [7:0]       rdata,
  output logic             rdata_valid,
  output logic             done,
  output logic             err,
  output logic             f_cs,
  output logic             f_we,
  output logic             f_re,
  output logic [23:0]      f_addr,
  output logic [7:0]       f_in,
  input  logic [7:0]       f_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [23:0]      cur_q, cur_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             refused_q, refused_d;
  logic             req_ready_q, req_ready_d;
  logic             f_cs_q, f_cs_d;
  logic             f_we_q, f_we_d;
  logic             f_re_q, f_re_d;
  logic [23:0]      f_addr_q, f_addr_d;
  logic [7:0]       f_in_q, f_in_d;
  logic             capture_q, capture_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             rdata_valid_q, rdata_valid_d;

  logic [24:0]      end_addr;
  logic             protect;

  // Next-state, counters and strobe generation.
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    cnt_d     = cnt_q;
    refused_d = refused_q;
    f_cs_d    = 1'b0;
    f_we_d    = 1'b0;
    f_re_d    = 1'b0;
    f_addr_d  = f_addr_q;
    f_in_d    = f_in_q;

    // Last byte touched by the request; bit 24 catches a wrap past 0xFFFFFF.
    end_addr = {1'b0, req_addr} + {{(25 - LEN_W){1'b0}}, req_len};
    protect  = (req_addr[23:20] == 4'hF) || (end_addr[23:20] == 4'hF) || end_addr[24];

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          cnt_d     = req_len;
          refused_d = 1'b0;
          if (req_write) begin
            if (protect) begin
              refused_d = 1'b1;
              state_d   = S_FIN;
            end else begin
              cur_d   = req_addr;
              state_d = S_WRITE;
            end
          end else begin
            // First read beat is issued straight from the accept edge so the
            // strobe lands in the cycle right after the handshake.
            f_cs_d   = 1'b1;
            f_re_d   = 1'b1;
            f_addr_d = req_addr;
            cur_d    = req_addr + 24'd1;
            state_d  = (req_len == '0) ? S_DRAIN : S_READ;
          end
        end
      end

      S_WRITE: begin
        if (wdata_valid) begin
          f_cs_d   = 1'b1;
          f_we_d   = 1'b1;
          f_addr_d = cur_q;
          f_in_d   = wdata;
          cur_d    = cur_q + 24'd1;
          cnt_d    = cnt_q - 1'b1;
          // The final write strobe is still on the bus next cycle; DRAIN
          // lets it retire before done is raised.
          if (cnt_q == '0) state_d = S_DRAIN;
        end
      end

      S_READ: begin
        // cnt_q holds the beats still to issue, including this one.
        f_cs_d   = 1'b1;
        f_re_d   = 1'b1;
        f_addr_d = cur_q;
        cur_d    = cur_q + 24'd1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == {{(LEN_W - 1){1'b0}}, 1'b1}) state_d = S_DRAIN;
      end

      S_DRAIN: begin
        // Leave once no read strobe or read capture is still in flight.
        if (!capture_q && !(f_cs_q && f_re_q)) state_d = S_FIN;
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_ready_d = (state_d == S_IDLE);
  end

  // Read return path: flag the cycle f_out is valid, then register it.
  always_comb begin
    capture_d     = f_cs_q & f_re_q;
    rdata_valid_d = capture_q;
    rdata_d       = capture_q ? f_out : rdata_q;
  end

  // State and output registers; reset drops every strobe immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cur_q         <= '0;
      cnt_q         <= '0;
      refused_q     <= 1'b0;
      req_ready_q   <= 1'b0;
      f_cs_q        <= 1'b0;
      f_we_q        <= 1'b0;
      f_re_q        <= 1'b0;
      f_addr_q      <= '0;
      f_in_q        <= '0;
      capture_q     <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      cnt_q         <= cnt_d;
      refused_q     <= refused_d;
      req_ready_q   <= req_ready_d;
      f_cs_q        <= f_cs_d;
      f_we_q        <= f_we_d;
      f_re_q        <= f_re_d;
      f_addr_q      <= f_addr_d;
      f_in_q        <= f_in_d;
      capture_q     <= capture_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign wdata_ready = (state_q == S_WRITE);
  assign done        = (state_q == S_FIN);
  assign err         = (state_q == S_FIN) && refused_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign f_cs        = f_cs_q;
  assign f_we        = f_we_q;
  assign f_re        = f_re_q;
  assign f_addr      = f_addr_q;
  assign f_in        = f_in_q;

endmodule

// File: tb/tb_flash_master.sv
// Scoreboard bench for flash_master: stimulus pushes expected flash strobes,
// read data and done/err pulses (with their cycle numbers) into queues; a
// negedge monitor pops and compares whenever the DUT presents one.
module tb_flash_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [23:0] req_addr;
  logic [7:0]  req_len;
  logic [7:0]  wdata;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [7:0]  rdata;
  logic        rdata_valid;
  logic        done;
  logic        err;
  logic        f_cs, f_we, f_re;
  logic [23:0] f_addr;
  logic [7:0]  f_in;
  logic [7:0]  f_out;

  flash_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .err(err),
    .f_cs(f_cs), .f_we(f_we), .f_re(f_re), .f_addr(f_addr), .f_in(f_in),
    .f_out(f_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] addr;
    logic [7:0]  data;
    logic [31:0] cyc;
  } exp_t;

  exp_t q_fw[$];
  exp_t q_fr[$];
  exp_t q_rd[$];
  exp_t q_dn[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] fmem [logic [23:0]];
  logic [7:0] gold [logic [23:0]];

  // Power-on contents of the flash array for locations never written.
  function automatic logic [7:0] init_b(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] expb(input logic [23:0] a);
    if (gold.exists(a)) return gold[a];
    return init_b(a);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic unexp(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got unexpected event want none (cycle %0d)", nm, cyc);
  endtask

  // Cycle counter: at a negedge, cyc is the index of the current cycle.
  always @(posedge clk) cyc <= cyc + 1;

  // Flash array model: write on cs&we, read data valid the cycle after cs&re.
  always @(posedge clk) begin
    if (f_cs && f_we) fmem[f_addr] = f_in;
    if (f_cs && f_re) f_out <= fmem.exists(f_addr) ? fmem[f_addr] : init_b(f_addr);
  end

  // Monitor: compare each presented DUT event against the scoreboard head.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (f_cs) begin
        chk("we_re_exclusive", 64'(f_we & f_re), 64'd0);
        if (f_we) begin
          if (q_fw.size() == 0) unexp("fw_strobe");
          else begin
            e = q_fw.pop_front();
            chk("fw_addr", 64'(f_addr), 64'(e.addr));
            chk("fw_data", 64'(f_in), 64'(e.data));
            chk("fw_cycle", 64'(cyc), 64'(e.cyc));
          end
        end else if (f_re) begin
          if (q_fr.size() == 0) unexp("fr_strobe");
          else begin
            e = q_fr.pop_front();
            chk("fr_addr", 64'(f_addr), 64'(e.addr));
            chk("fr_cycle", 64'(cyc), 64'(e.cyc));
          end
        end else begin
          unexp("cs_without_we_re");
        end
      end
      if (rdata_valid) begin
        if (q_rd.size() == 0) unexp("rdata_valid");
        else begin
          e = q_rd.pop_front();
          chk("rdata", 64'(rdata), 64'(e.data));
          chk("rdata_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (done) begin
        if (q_dn.size() == 0) unexp("done");
        else begin
          e = q_dn.pop_front();
          chk("err", 64'(err), 64'(e.data[0]));
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else begin
        chk("err_without_done", 64'(err), 64'd0);
      end
    end
  end

  // Present a request; acc is the cycle whose closing edge is the handshake.
  task automatic req(input logic wr, input logic [23:0] a, input logic [7:0] l, output int acc);
    acc = -1;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_len   = l;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL req_timeout: got req_ready=0 want 1 within 50 cycles");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    $display("req %s addr=%06h len=%0d accepted at cycle %0d", wr ? "WR" : "RD", a, l, acc);
  endtask

  task automatic rd_burst(input logic [23:0] a, input logic [7:0] l);
    int acc;
    logic [23:0] ad;
    req(1'b0, a, l, acc);
    for (int i = 0; i <= int'(l); i++) begin
      ad = a + 24'(i);
      q_fr.push_back('{addr: ad, data: 8'h00, cyc: 32'(acc + 1 + i)});
      q_rd.push_back('{addr: ad, data: expb(ad), cyc: 32'(acc + 3 + i)});
    end
    q_dn.push_back('{addr: 24'h0, data: 8'h00, cyc: 32'(acc + int'(l) + 4)});
    wait (q_dn.size() == 0);
  endtask

  // Write burst; pat gives wdata_valid per cycle starting the cycle after accept.
  task automatic wr_burst(input logic [23:0] a, input logic [7:0] l,
                          input logic [15:0] pat, input int npat, input logic [7:0] base);
    int acc;
    int beat;
    int last;
    logic [23:0] ad;
    logic [7:0] d;
    req(1'b1, a, l, acc);
    beat = 0;
    last = acc;
    for (int j = 0; j < npat; j++) begin
      if (beat > int'(l)) break;
      wdata_valid = pat[j];
      d = base + 8'(beat);
      wdata = d;
      if (pat[j]) begin
        ad = a + 24'(beat);
        q_fw.push_back('{addr: ad, data: d, cyc: 32'(cyc + 1)});
        gold[ad] = d;
        last = cyc + 1;
        beat++;
      end
      @(posedge clk); #1;
    end
    wdata_valid = 1'b0;
    q_dn.push_back('{addr: 24'h0, data: 8'h00, cyc: 32'(last + 1)});
    wait (q_dn.size() == 0);
  endtask

  // Refused write: done/err next cycle, no strobes, wdata never taken.
  task automatic prot_wr(input logic [23:0] a, input logic [7:0] l);
    int acc;
    req(1'b1, a, l, acc);
    q_dn.push_back('{addr: 24'h0, data: 8'h01, cyc: 32'(acc + 1)});
    wdata_valid = 1'b1;
    wdata       = 8'hEE;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("prot_wdata_ready", 64'(wdata_ready), 64'd0);
      chk("prot_f_cs", 64'(f_cs), 64'd0);
      if (k == 2) chk("prot_req_ready_back", 64'(req_ready), 64'd1);
    end
    wdata_valid = 1'b0;
  endtask

  initial begin : stim
    int acc;
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    req_len     = '0;
    wdata       = '0;
    wdata_valid = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_wdata_ready", 64'(wdata_ready), 64'd0);
    chk("rst_rdata", 64'({rdata, rdata_valid}), 64'd0);
    chk("rst_done_err", 64'({done, err}), 64'd0);
    chk("rst_strobes", 64'({f_cs, f_we, f_re}), 64'd0);
    chk("rst_f_addr_in", 64'({f_addr, f_in}), 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Single write then read back.
    wr_burst(24'h012345, 8'd0, 16'h0001, 1, 8'hA5);
    rd_burst(24'h012345, 8'd0);
    // Burst read across a sector boundary.
    rd_burst(24'h0FFFFE, 8'd3);
    // Write protection boundary.
    prot_wr(24'hEFFFFE, 8'd3);
    wr_burst(24'hEFFFFC, 8'd3, 16'h000F, 4, 8'h10);
    rd_burst(24'hEFFFFC, 8'd3);
    prot_wr(24'hF00000, 8'd0);
    // Reads are allowed in the top sector, and wrap at the top of memory.
    rd_burst(24'hF00010, 8'd2);
    rd_burst(24'hFFFFFF, 8'd1);
    // Stalled write: valid toggles 1,0,1,0,1.
    wr_burst(24'h200010, 8'd2, 16'h0015, 5, 8'h61);
    rd_burst(24'h200010, 8'd2);

    // Reset mid-read after two of eight beats.
    req(1'b0, 24'h300000, 8'd7, acc);
    q_fr.push_back('{addr: 24'h300000, data: 8'h00, cyc: 32'(acc + 1)});
    q_fr.push_back('{addr: 24'h300001, data: 8'h00, cyc: 32'(acc + 2)});
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_strobes", 64'({f_cs, f_we, f_re}), 64'd0);
    chk("midrst_f_addr_in", 64'({f_addr, f_in}), 64'd0);
    chk("midrst_rdata_valid", 64'(rdata_valid), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    chk("midrst_fr_drained", 64'(q_fr.size()), 64'd0);

    // Normal operation after reset.
    wr_burst(24'h000000, 8'd1, 16'h0003, 2, 8'hC3);
    rd_burst(24'hFFFFFF, 8'd2);

    repeat (10) @(negedge clk);
    chk("q_fw_empty", 64'(q_fw.size()), 64'd0);
    chk("q_fr_empty", 64'(q_fr.size()), 64'd0);
    chk("q_rd_empty", 64'(q_rd.size()), 64'd0);
    chk("q_dn_empty", 64'(q_dn.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time limit so a stuck handshake can never hang the run.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

endmodule
